step_sequencer: RTL
===================

# step_sequencer

Motion sequencer that sits in front of `dual_hbridge` and drives its `step`/`dir` inputs. It accepts move commands (direction, step count, step interval) through a valid/ready queue and executes them back-to-back. Every pulse is emitted with a fixed width and exact spacing, and direction changes get a guaranteed setup time. It keeps a signed absolute position count so firmware can track the motor without counting pulses itself.

## Interface
- `DEPTH`, 4: command queue depth, power of two, ≥2
- `STEP_WIDTH`, 4: cycles `step` is held high per pulse, ≥1
- `DIR_SETUP`, 16: cycles between a `dir` change and the next `step` rise, ≥1

- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: synchronous, active-high
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: queue not full
- `cmd_dir` in 1: direction for the move (1 = forward)
- `cmd_steps` in 32: pulse count; 0 is legal
- `cmd_interval` in 24: cycles from one `step` rise to the next
- `abort` in 1: flush queue and stop immediately
- `pos_clear` in 1: zero the position counter
- `step` out 1: to `dual_hbridge.step`
- `dir` out 1: to `dual_hbridge.dir`
- `busy` out 1: move executing or queue non-empty
- `move_done` out 1: one-cycle pulse when a move completes
- `position` out 32: signed step position

## Operation
- **Queue**
  - A command is accepted on any cycle with `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`. It is computed from registered occupancy and never depends on a same-cycle pop.
  - The queue holds `DEPTH` entries.
- **Interval clamp:** effective interval = max(`cmd_interval`, `STEP_WIDTH`+1).
- **State IDLE**
  - If the queue is non-empty, pop it. If the popped `cmd_steps`=0, pulse `move_done` next cycle and stay IDLE.
  - Otherwise, if `cmd_dir` != `dir`, go to SETUP; else go to PULSE.
- **State SETUP**
  - `dir` takes the new value on entry.
  - After `DIR_SETUP` cycles, go to PULSE.
- **State PULSE**
  - `step` is high for `STEP_WIDTH` cycles.
  - On the rising cycle, `position` += 1 if `dir`=1, else −1 (two's-complement wrap).
  - The remaining-step counter decrements on the rising cycle.
  - Then go to INTERVAL.
- **State INTERVAL**
  - `step` is low until the effective interval, counted from the rise, expires.
  - If steps remain, go to PULSE.
  - If not, pulse `move_done`, and in that same cycle pop the next command if one is present (same decisions as IDLE). Otherwise go to IDLE.
- **`busy`** is high in SETUP/PULSE/INTERVAL, or whenever the queue is non-empty.
- **`abort`**
  - Takes effect next cycle: queue emptied, `step`=0, state IDLE, counters cleared.
  - `move_done` is not pulsed, and `dir` and `position` are held.
  - `abort` has priority over a same-cycle push: the command is dropped and `cmd_ready` reads 0 while `abort` is high.
- **`pos_clear`**
  - Sets `position` to 0.
  - It has priority over a same-cycle step rise; that step is not counted.

## Timing
- **Reset values:** `step`=0, `dir`=0, `busy`=0, `move_done`=0, `position`=0, queue empty, state IDLE. `cmd_ready`=1 from the first cycle after reset.
- **Reset mid-move:** behaves as an immediate reset; no `move_done` is pulsed.
- **Latency, idle with same direction:** `step` rises 2 cycles after the accepting edge (push edge, then pop edge).
- **Latency with a direction change:** `dir` changes 2 cycles after accept, and `step` rises exactly `DIR_SETUP` cycles after `dir` changes.
- **Pulse spacing:** successive `step` rises within a move are exactly the effective interval apart.
- **Back-to-back moves, same direction:** the first rise of the next move is exactly the previous move's effective interval after its last rise. There is no idle gap.
- **Back-to-back moves, direction reversal:** the gap between the last rise and the next rise is effective interval + `DIR_SETUP`.
- **`move_done`:** asserted one cycle, on the interval-expiry cycle of the last pulse.
- **Outputs:** `step` and `dir` are registered and glitch-free.
- **Queue boundaries:**
  - A push when full is ignored (`cmd_ready`=0).
  - A pop when empty does not occur.
  - A push into an empty queue while IDLE is poppable on the next cycle.

## Test plan
- **Single move:** after reset, push {dir=1, steps=3, interval=10} → 3 `step` pulses 4 cycles wide, rises 10 cycles apart; `dir` goes 1 with `DIR_SETUP`=16 before the first rise; `position`=3; one `move_done`; then `busy`=0.
- **Back-to-back and full queue:**
  - Push {1,2,8} then {1,2,8} → 4 rises all spaced 8, two `move_done` pulses.
  - Push 5 commands with no gaps → `cmd_ready` drops after 4 are queued, and the 5th is held until a pop.
- **Reversal:** push {1,2,8} then {0,2,8} → the gap between the 2nd and 3rd rise is 8+16=24; `position` returns to 0.
- **Zero and clamp:**
  - {1,0,8} → no pulses, `move_done` one cycle after pop.
  - {1,2,1} → rises 5 apart (clamped).
- **Abort mid-move:** `abort` during the 2nd pulse of {1,10,20} with 2 moves queued → `step` low next cycle, `busy`=0, no `move_done`, `position`=2, `dir` held at 1.
- **Position clear:** `pos_clear` coincident with a `step` rise → `position`=0. Reset asserted mid-move → all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/step_sequencer.sv
// Step/dir motion sequencer: queued move commands become evenly spaced step
// pulses, with direction setup time and a signed running position count.
module step_sequencer #(
  parameter int DEPTH      = 4,   // power of two, >= 2
  parameter int STEP_WIDTH = 4,
  parameter int DIR_SETUP  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [31:0] cmd_steps,
  input  logic [23:0] cmd_interval,
  input  logic        abort,
  input  logic        pos_clear,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        move_done,
  output logic [31:0] position
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [23:0] MIN_IVL = 24'(STEP_WIDTH + 1);
  localparam logic [23:0] SW_M1   = 24'(STEP_WIDTH - 1);
  localparam logic [23:0] DS_M1   = 24'(DIR_SETUP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_INTERVAL} state_t;

  typedef struct packed {
    logic        dir;
    logic [31:0] steps;
    logic [23:0] interval;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  state_t        state_q, state_d;
  logic          step_q, step_d, dir_q, dir_d, done_q, done_d;
  logic [31:0]   pos_q, pos_d, rem_q, rem_d;
  logic [23:0]   tmr_q, tmr_d, ivl_m1_q, ivl_m1_d;
  logic          push, pop, rise, launch;
  cmd_t          head, wr_cmd;
  logic [23:0]   head_ivl_m1;

  // Small queue: head is read combinationally so a pop can start a pulse on the same edge.
  assign head        = mem_q[rd_ptr_q];
  assign wr_cmd      = {cmd_dir, cmd_steps, cmd_interval};
  assign head_ivl_m1 = ((head.interval < MIN_IVL) ? MIN_IVL : head.interval) - 24'd1;

  assign cmd_ready = (count_q != (AW+1)'(DEPTH)) && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state_q != S_IDLE) || (count_q != '0);
  assign step      = step_q;
  assign dir       = dir_q;
  assign move_done = done_q;
  assign position  = pos_q;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    rem_d    = rem_q;
    tmr_d    = tmr_q;
    ivl_m1_d = ivl_m1_q;
    pop      = 1'b0;
    rise     = 1'b0;
    launch   = 1'b0;

    // tmr_q counts cycles since the last step rise (or since entering SETUP).
    case (state_q)
      S_IDLE:  launch = (count_q != '0);
      S_SETUP: begin
        if (tmr_q == DS_M1) rise = 1'b1;
        else                tmr_d = tmr_q + 24'd1;
      end
      S_PULSE: begin
        tmr_d = tmr_q + 24'd1;
        if (tmr_q == SW_M1) begin
          step_d  = 1'b0;
          state_d = S_INTERVAL;
        end
      end
      S_INTERVAL: begin
        if (tmr_q == ivl_m1_q) begin
          if (rem_q != '0) begin
            rise = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            // A zero-length head waits one cycle so its move_done stays a distinct pulse.
            launch  = (count_q != '0) && (head.steps != '0);
          end
        end else begin
          tmr_d = tmr_q + 24'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      pop      = 1'b1;
      ivl_m1_d = head_ivl_m1;
      rem_d    = head.steps;
      if (head.steps == '0) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (head.dir != dir_q) begin
        dir_d   = head.dir;
        tmr_d   = '0;
        state_d = S_SETUP;
      end else begin
        rise = 1'b1;
      end
    end

    if (rise) begin
      step_d  = 1'b1;
      tmr_d   = '0;
      rem_d   = rem_d - 32'd1;
      state_d = S_PULSE;
    end

    if (abort) begin
      state_d  = S_IDLE;
      step_d   = 1'b0;
      dir_d    = dir_q;
      done_d   = 1'b0;
      rem_d    = '0;
      tmr_d    = '0;
      ivl_m1_d = '0;
      pop      = 1'b0;
      rise     = 1'b0;
    end

    if (pos_clear) pos_d = '0;
    else if (rise) pos_d = dir_d ? pos_q + 32'd1 : pos_q - 32'd1;
    else           pos_d = pos_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
      pos_q    <= '0;
      rem_q    <= '0;
      tmr_q    <= '0;
      ivl_m1_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      pos_q    <= pos_d;
      rem_q    <= rem_d;
      tmr_q    <= tmr_d;
      ivl_m1_q <= ivl_m1_d;
      if (abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

endmodule
